// File: rtl/vga_fetch_pkg.sv
// Shared types and default constants for the VGA pixel fetch path.
package vga_fetch_pkg;

    // Fill-side fetch controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        RECV  = 2'd3
    } fetch_state_t;

    localparam int unsigned BURST_LEN_DEF       = 4;
    localparam int unsigned WORDS_PER_FRAME_DEF = 102400;

endpackage

// File: rtl/fifo_level_cnt.sv
// Up/down occupancy counter for a FIFO wrapper; saturates at 0 and DEPTH.
module fifo_level_cnt #(
    parameter int unsigned DEPTH = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           inc,
    input  logic                           dec,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);

    // Simultaneous inc and dec cancel; otherwise step within [0, DEPTH]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (inc && !dec && (level < LW'(DEPTH))) begin
            level <= level + LW'(1);
        end else if (dec && !inc && (level != '0)) begin
            level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Fill-side controller for the pixel sync_fifo: issues burst reads to frame
// memory when the FIFO has room, forwards returned beats into the FIFO,
// passes display pops through and tracks occupancy / underflow.
// Optional: PIXEL_FETCH_UFLOW_CNT_EN adds a saturating underflow-cycle count.
module pixel_fetch_ctrl
    import vga_fetch_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH      = 36,
    parameter int unsigned FIFO_DEPTH      = 10,
    parameter int unsigned BURST_LEN       = BURST_LEN_DEF,
    parameter int unsigned WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
    parameter int unsigned ADDR_WIDTH      = 17
) (
    input  logic                               clk,
    input  logic                               clr_n_in,
    input  logic                               frame_start_in,
    output logic                               mem_req_out,
    output logic [ADDR_WIDTH-1:0]              mem_addr_out,
    input  logic                               mem_ack_in,
    input  logic                               mem_valid_in,
    input  logic [FIFO_WIDTH-1:0]              mem_data_in,
    output logic                               fifo_we_out,
    output logic [FIFO_WIDTH-1:0]              fifo_data_out,
    input  logic                               fifo_full_in,
    input  logic                               fifo_empty_in,
    input  logic                               disp_rd_in,
    output logic                               fifo_rd_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level_out,
    output logic                               underflow_out,
`ifdef PIXEL_FETCH_UFLOW_CNT_EN
    output logic [7:0]                         uflow_cnt_out,
`endif
    output logic                               busy_out
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned AW1    = ADDR_WIDTH + 1;

    fetch_state_t            state, state_nx;
    logic [ADDR_WIDTH-1:0]   addr, addr_nx;
    logic [ADDR_WIDTH-1:0]   mem_addr_nx;
    logic [BEAT_W-1:0]       beat, beat_nx;
    logic                    pend, pend_nx;
    logic                    req_nx;
    logic                    uflow_nx;
    logic [31:0]             need_c;
    logic                    room_c;
    logic [AW1-1:0]          addr_inc_c;
    logic                    uflow_ev_c;

    // Display-side pop passes straight through when the FIFO has data
    assign fifo_rd_out = disp_rd_in & ~fifo_empty_in;
    assign uflow_ev_c  = disp_rd_in & fifo_empty_in;

    // Room test counts the write already in the output register
    assign need_c     = 32'(level_out) + 32'(fifo_we_out) + BURST_LEN;
    assign room_c     = (need_c <= FIFO_DEPTH);
    assign addr_inc_c = AW1'(addr) + AW1'(BURST_LEN);

    // Next-state, address, beat and restart bookkeeping
    always_comb begin
        state_nx    = state;
        addr_nx     = addr;
        beat_nx     = beat;
        pend_nx     = pend;
        req_nx      = 1'b0;
        mem_addr_nx = mem_addr_out;
        uflow_nx    = underflow_out;

        if (frame_start_in) begin
            uflow_nx = 1'b0;
        end else if (uflow_ev_c) begin
            uflow_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                if (frame_start_in) begin
                    addr_nx  = '0;
                    pend_nx  = 1'b0;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                if (frame_start_in) begin
                    addr_nx = '0;
                end else if (room_c) begin
                    state_nx    = REQ;
                    req_nx      = 1'b1;
                    mem_addr_nx = addr;
                    beat_nx     = '0;
                end
            end
            REQ: begin
                req_nx = 1'b1;
                if (frame_start_in) begin
                    pend_nx = 1'b1;
                end
                if (mem_ack_in) begin
                    req_nx   = 1'b0;
                    state_nx = RECV;
                end
            end
            RECV: begin
                if (frame_start_in) begin
                    pend_nx = 1'b1;
                end
                if (mem_valid_in) begin
                    if (beat == BEAT_W'(BURST_LEN - 1)) begin
                        beat_nx = '0;
                        if (pend || frame_start_in) begin
                            addr_nx  = '0;
                            pend_nx  = 1'b0;
                            state_nx = CHECK;
                        end else begin
                            addr_nx  = addr_inc_c[ADDR_WIDTH-1:0];
                            state_nx = (addr_inc_c == AW1'(WORDS_PER_FRAME)) ? IDLE : CHECK;
                        end
                    end else begin
                        beat_nx = beat + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge clr_n_in) begin
        if (!clr_n_in) begin
            state         <= IDLE;
            addr          <= '0;
            beat          <= '0;
            pend          <= 1'b0;
            mem_req_out   <= 1'b0;
            mem_addr_out  <= '0;
            underflow_out <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            state         <= state_nx;
            addr          <= addr_nx;
            beat          <= beat_nx;
            pend          <= pend_nx;
            mem_req_out   <= req_nx;
            mem_addr_out  <= mem_addr_nx;
            underflow_out <= uflow_nx;
            busy_out      <= (state_nx != IDLE);
        end
    end

    // Return beats are registered once on their way into the FIFO
    always_ff @(posedge clk or negedge clr_n_in) begin
        if (!clr_n_in) begin
            fifo_we_out   <= 1'b0;
            fifo_data_out <= '0;
        end else begin
            fifo_we_out <= mem_valid_in && (state == RECV);
            if (mem_valid_in && (state == RECV)) begin
                fifo_data_out <= mem_data_in;
            end
        end
    end

    fifo_level_cnt #(
        .DEPTH (FIFO_DEPTH)
    ) u_level (
        .clk   (clk),
        .rst_n (clr_n_in),
        .inc   (fifo_we_out),
        .dec   (fifo_rd_out),
        .level (level_out)
    );

`ifdef PIXEL_FETCH_UFLOW_CNT_EN
    // Saturating count of underflow cycles within the current frame
    always_ff @(posedge clk or negedge clr_n_in) begin
        if (!clr_n_in) begin
            uflow_cnt_out <= '0;
        end else if (frame_start_in) begin
            uflow_cnt_out <= '0;
        end else if (uflow_ev_c && (uflow_cnt_out != 8'hFF)) begin
            uflow_cnt_out <= uflow_cnt_out + 8'd1;
        end
    end
`endif

    // Writing into a full FIFO means the room check was wrong
    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (!clr_n_in) !(fifo_we_out && fifo_full_in)
    );

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Directed bench for pixel_fetch_ctrl: a default-frame instance and a
// short-frame (8 words) instance share the clock and a selectable driver.
module tb_pixel_fetch_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        sel;
    logic        fs_drv, ack_drv, valid_drv;
    logic [35:0] data_drv;
    logic        disp_rd, empty;

    // Main instance
    logic        req_d, we_d, rd_d, uf_d, busy_d;
    logic [16:0] addr_d;
    logic [35:0] fdata_d;
    logic [3:0]  level_d;
    // Short-frame instance
    logic        req_s, we_s, rd_s, uf_s, busy_s;
    logic [16:0] addr_s;
    logic [35:0] fdata_s;
    logic [3:0]  level_s;
`ifdef PIXEL_FETCH_UFLOW_CNT_EN
    logic [7:0]  ucnt_d, ucnt_s;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wire         m_req   = sel ? req_s   : req_d;
    wire [16:0]  m_addr  = sel ? addr_s  : addr_d;
    wire         m_we    = sel ? we_s    : we_d;
    wire [35:0]  m_fdata = sel ? fdata_s : fdata_d;

    pixel_fetch_ctrl dut (
        .clk            (clk),
        .clr_n_in       (clr_n),
        .frame_start_in (fs_drv & ~sel),
        .mem_req_out    (req_d),
        .mem_addr_out   (addr_d),
        .mem_ack_in     (ack_drv & ~sel),
        .mem_valid_in   (valid_drv & ~sel),
        .mem_data_in    (data_drv),
        .fifo_we_out    (we_d),
        .fifo_data_out  (fdata_d),
        .fifo_full_in   (1'b0),
        .fifo_empty_in  (empty),
        .disp_rd_in     (disp_rd & ~sel),
        .fifo_rd_out    (rd_d),
        .level_out      (level_d),
        .underflow_out  (uf_d),
`ifdef PIXEL_FETCH_UFLOW_CNT_EN
        .uflow_cnt_out  (ucnt_d),
`endif
        .busy_out       (busy_d)
    );

    pixel_fetch_ctrl #(.WORDS_PER_FRAME(8)) dut_s (
        .clk            (clk),
        .clr_n_in       (clr_n),
        .frame_start_in (fs_drv & sel),
        .mem_req_out    (req_s),
        .mem_addr_out   (addr_s),
        .mem_ack_in     (ack_drv & sel),
        .mem_valid_in   (valid_drv & sel),
        .mem_data_in    (data_drv),
        .fifo_we_out    (we_s),
        .fifo_data_out  (fdata_s),
        .fifo_full_in   (1'b0),
        .fifo_empty_in  (1'b1),
        .disp_rd_in     (1'b0),
        .fifo_rd_out    (rd_s),
        .level_out      (level_s),
        .underflow_out  (uf_s),
`ifdef PIXEL_FETCH_UFLOW_CNT_EN
        .uflow_cnt_out  (ucnt_s),
`endif
        .busy_out       (busy_s)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!m_req && n < 30) begin
            tick();
            n++;
        end
        check_eq({tag, "_req_seen"}, 64'(m_req), 64'd1);
    endtask

    // Wait for a request, check its address, ack it and return 4 beats
    task automatic burst(input logic [16:0] exp_addr, input string tag);
        wait_req(tag);
        check_eq({tag, "_addr"}, 64'(m_addr), 64'(exp_addr));
        ack_drv = 1'b1;
        tick();
        ack_drv = 1'b0;
        check_eq({tag, "_req_drop"}, 64'(m_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            valid_drv = 1'b1;
            data_drv  = 36'(36'h5_0000_0000 + 36'(exp_addr) * 16 + 36'(i));
            tick();
            check_eq({tag, "_we"}, 64'(m_we), 64'd1);
            check_eq({tag, "_wdata"}, 64'(m_fdata), 64'(data_drv));
        end
        valid_drv = 1'b0;
    endtask

    task automatic pop_n(input int n);
        empty   = 1'b0;
        disp_rd = 1'b1;
        repeat (n) tick();
        disp_rd = 1'b0;
    endtask

    task automatic pulse_fs();
        fs_drv = 1'b1;
        tick();
        fs_drv = 1'b0;
    endtask

    initial begin
        bit seen;
        clr_n = 1'b0; sel = 1'b0; fs_drv = 1'b0; ack_drv = 1'b0; valid_drv = 1'b0;
        data_drv = '0; disp_rd = 1'b0; empty = 1'b0;
        repeat (3) @(posedge clk);
        #1 clr_n = 1'b1;

        // Reset state
        check_eq("rst_req",   64'(req_d),   64'd0);
        check_eq("rst_addr",  64'(addr_d),  64'd0);
        check_eq("rst_we",    64'(we_d),    64'd0);
        check_eq("rst_level", 64'(level_d), 64'd0);
        check_eq("rst_uf",    64'(uf_d),    64'd0);
        check_eq("rst_busy",  64'(busy_d),  64'd0);
        check_eq("rst_busy_s", 64'(busy_s), 64'd0);

        // First burst from word 0, second follows at word 4
        pulse_fs();
        check_eq("busy_after_fs", 64'(busy_d), 64'd1);
        burst(17'd0, "b0");
        tick();
        check_eq("b0_level", 64'(level_d), 64'd4);
        check_eq("b0_we_done", 64'(we_d), 64'd0);
        burst(17'd4, "b1");
        repeat (4) tick();
        check_eq("two_burst_level", 64'(level_d), 64'd8);
        check_eq("no_third_req", 64'(req_d), 64'd0);

        // One pop: level 7, still no room
        empty = 1'b0; disp_rd = 1'b1;
        #1 check_eq("pop_rd", 64'(rd_d), 64'd1);
        tick();
        disp_rd = 1'b0;
        repeat (2) tick();
        check_eq("pop1_level", 64'(level_d), 64'd7);
        check_eq("pop1_no_req", 64'(req_d), 64'd0);
        pop_n(2);
        check_eq("pop3_level", 64'(level_d), 64'd5);
        check_eq("pop3_req", 64'(req_d), 64'd1);

        // Burst at 8 with a pop landing on the same cycle as a write at level 6
        wait_req("b2");
        check_eq("b2_addr", 64'(addr_d), 64'd8);
        ack_drv = 1'b1; tick(); ack_drv = 1'b0;
        valid_drv = 1'b1; tick();
        valid_drv = 1'b0; tick();
        valid_drv = 1'b1; tick();
        valid_drv = 1'b0;
        disp_rd = 1'b1;
        #1;
        check_eq("same_we", 64'(we_d), 64'd1);
        check_eq("same_rd", 64'(rd_d), 64'd1);
        check_eq("same_level_pre", 64'(level_d), 64'd6);
        tick();
        disp_rd = 1'b0;
        check_eq("same_level_post", 64'(level_d), 64'd6);
        valid_drv = 1'b1; tick(); tick();
        valid_drv = 1'b0; tick();
        check_eq("b2_level", 64'(level_d), 64'd8);

        // Underflow: pop while empty
        empty = 1'b1; disp_rd = 1'b1;
        #1 check_eq("uf_rd_blocked", 64'(rd_d), 64'd0);
        tick();
        disp_rd = 1'b0; empty = 1'b0;
        check_eq("uf_set", 64'(uf_d), 64'd1);
        check_eq("uf_level", 64'(level_d), 64'd8);
        repeat (2) tick();
        check_eq("uf_held", 64'(uf_d), 64'd1);
`ifdef PIXEL_FETCH_UFLOW_CNT_EN
        check_eq("uf_cnt", 64'(ucnt_d), 64'd1);
`endif
        pulse_fs();
        check_eq("uf_cleared", 64'(uf_d), 64'd0);
`ifdef PIXEL_FETCH_UFLOW_CNT_EN
        check_eq("uf_cnt_cleared", 64'(ucnt_d), 64'd0);
`endif

        // Restart in CHECK zeroed the address; walk bursts up to word 40
        for (int b = 0; b < 10; b++) begin
            pop_n(4);
            burst(17'(b * 4), "walk");
        end
        pop_n(4);
        wait_req("b40");
        check_eq("b40_addr", 64'(addr_d), 64'd40);
        ack_drv = 1'b1; tick(); ack_drv = 1'b0;
        valid_drv = 1'b1; tick();
        fs_drv = 1'b1; tick();
        fs_drv = 1'b0;
        tick(); tick();
        valid_drv = 1'b0; tick();
        check_eq("restart_level", 64'(level_d), 64'd8);
        check_eq("restart_no_req", 64'(req_d), 64'd0);
        pop_n(4);
        wait_req("restart");
        check_eq("restart_addr", 64'(addr_d), 64'd0);

        // Short frame: two bursts then IDLE
        sel = 1'b1;
        pulse_fs();
        check_eq("s_busy", 64'(busy_s), 64'd1);
        burst(17'd0, "s0");
        burst(17'd4, "s1");
        check_eq("s_idle_busy", 64'(busy_s), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (req_s) seen = 1'b1;
        end
        check_eq("s_no_req_idle", 64'(seen), 64'd0);
        check_eq("s_level", 64'(level_s), 64'd8);
        pulse_fs();
        check_eq("s_busy_again", 64'(busy_s), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
